// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle RV32I-subset datapath.
// Decodes the opcode/funct fields held in IR and drives every datapath
// write enable and mux select, one state per clock.
// Optional feature macro: CTRL_HALT_ON_ILLEGAL_EN -- when defined, an unknown
// opcode in DECODE parks the FSM in HALT (all outputs 0, halted=1) until reset.
// Handshake: none; the datapath follows the FSM unconditionally, and the only
// asynchronous-to-state input (zero) is consumed combinationally in BRANCH.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic       RegWrite,
    output logic [3:0] ALUControl,
    output logic [3:0] state,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_EXEC_I    = 4'd9,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    state_t state_q;
    state_t state_d;

    // State register: reset always lands in FETCH on the next edge.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Debug view of the state; reads FETCH while reset is held.
    assign state = reset ? S_FETCH : state_q;

`ifdef CTRL_HALT_ON_ILLEGAL_EN
    logic halted_q;

    // Sticky illegal-opcode flag, set on the edge that enters HALT.
    always_ff @(posedge clk) begin
        if (reset)                  halted_q <= 1'b0;
        else if (state_d == S_HALT) halted_q <= 1'b1;
    end

    assign halted = halted_q & ~reset;
`else
    assign halted = 1'b0;
`endif

    // Next-state and Moore output decode; reset forces every output low.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        PCSource   = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                // Read the instruction and compute PC+4 into ALUOut.
                memRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = SRCB_4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // PC <= PC+4 from ALUOut while the branch target lands in ALUOut.
                PCWrite  = 1'b1;
                PCSource = 1'b1;
                ALUSrcB  = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ITYPE:     state_d = S_EXEC_I;
                    OP_BRANCH:    state_d = S_BRANCH;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_B;
                casez ({funct7_5, funct3})
                    4'b0000: ALUControl = ALU_ADD;
                    4'b1000: ALUControl = ALU_SUB;
                    4'b?111: ALUControl = ALU_AND;
                    4'b?110: ALUControl = ALU_OR;
                    default: ALUControl = ALU_BAD;
                endcase
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (funct3)
                    3'b000:  ALUControl = ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_BAD;
                endcase
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                // Compare via subtract; only the zero flag qualifies the PC load.
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_B;
                ALUControl = ALU_SUB;
                PCSource   = 1'b1;
                case (funct3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    default: PCWrite = 1'b0;
                endcase
                state_d = S_FETCH;
            end
`ifdef CTRL_HALT_ON_ILLEGAL_EN
            S_HALT: begin
                ALUControl = 4'b0000;
                state_d    = S_HALT;
            end
`endif
            default: begin
                ALUControl = 4'b0000;
                state_d    = S_FETCH;
            end
        endcase

        if (reset) begin
            PCWrite    = 1'b0;
            IorD       = 1'b0;
            memRead    = 1'b0;
            memWrite   = 1'b0;
            IRWrite    = 1'b0;
            MemtoReg   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = SRCB_B;
            PCSource   = 1'b0;
            RegWrite   = 1'b0;
            ALUControl = 4'b0000;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I subset datapath (PC, unified memory, IR, MDR, register file, A/B/ALUOut latches, operand/result muxes). It decodes the opcode and funct fields held in IR and sequences every datapath control line, one state per clock, for lw, sw, R-type add/sub/and/or, addi/andi/ori, beq and bne. It sits beside the datapath and is its only source of write enables and mux selects.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC load enable, unconditional or branch-qualified
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- memRead  out  1  memory read enable
- memWrite  out  1  memory write enable
- IRWrite  out  1  IR load enable
- MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = imm
- PCSource  out  1  0 = ALU result, 1 = ALUOut
- RegWrite  out  1  register file write enable
- ALUControl  out  4  0000 and, 0001 or, 0010 add, 0110 sub
- state  out  4  current state, for debug
- halted  out  1  sticky illegal-opcode flag

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, ALU_WB 7, BRANCH 8, EXEC_I 9, HALT 15.
- All outputs are Moore-decoded from state. The exception is PCWrite in BRANCH, which also depends on zero. Any output not listed for a state is 0, and ALUControl defaults to 0010.
- FETCH: memRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, add. ALUOut captures PC+4. PC is not written. Next state DECODE.
- DECODE: PCWrite=1, PCSource=1, so the PC loads PC+4 from ALUOut. In the same cycle ALUSrcA=0, ALUSrcB=10, add: the old PC plus imm (the branch target) lands in ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - other → FETCH (or HALT, see Configuration)
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: memRead=1, IorD=1. Next state MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1. Next state FETCH.
- MEM_WRITE: memWrite=1, IorD=1. Next state FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00.
  - ALUControl from {funct7_5, funct3}: 0/000 add, 1/000 sub, x/111 and, x/110 or, else 1111.
  - Next state ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10.
  - ALUControl from funct3: 000 add, 111 and, 110 or, else 1111. funct7_5 is ignored.
  - Next state ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=1.
  - PCWrite = zero if funct3=000, ~zero if funct3=001, else 0.
  - Next state FETCH.
- funct3 is not checked for lw/sw.
- Unsupported ALU funct (1111) still writes back; the datapath returns 0.

## Timing
- While reset is high, every output is forced to 0 combinationally, state reads FETCH, and halted reads 0. The next edge loads FETCH and clears halted.
- The first cycle after reset deasserts is FETCH.
- Reset asserted mid-instruction aborts it: no further writes occur, and FETCH follows.
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, branch 3.
- opcode and funct fields are sampled only from DECODE onward, which is one cycle after IRWrite.
- zero is sampled combinationally in BRANCH only.

## Configuration
- Macro: CTRL_HALT_ON_ILLEGAL_EN.
- Defined: an unknown opcode in DECODE goes to HALT. HALT holds all outputs at 0 and sets halted=1 until reset.
- Undefined: an unknown opcode returns to FETCH, HALT is unreachable, and halted is tied to 0.

## Test plan
- After reset, IR=0x01400193 (addi x3,x0,20): states 0→1→9→7→0. ALUControl=0010 and ALUSrcB=10 in EXEC_I. RegWrite=1 only in ALU_WB. PCWrite=1 only in DECODE.
- IR=0x0781A403 (lw x8,120(x3)): states 0→1→2→3→4→0. IorD=1 and memRead=1 in MEM_READ. MemtoReg=1 and RegWrite=1 in MEM_WB.
- R-type 0x40208033 (sub): ALUControl=0110 in EXEC_R. The same with funct7_5=0 gives 0010. funct3=111 gives 0000.
- beq (funct3=000) with zero=1 → PCWrite=1, PCSource=1 in BRANCH. With zero=0 → PCWrite=0. bne with zero=1 → PCWrite=0.
- opcode 0x7F:
  - With macro: state=15, halted=1, and all outputs stay 0 for 10 cycles.
  - Without macro: returns to FETCH.
- reset pulsed during MEM_READ → all outputs 0 that cycle, FETCH next cycle, and no RegWrite for the aborted lw.
